// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and helpers for the pipeline hazard controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Width needed for a counter that must reach max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard inputs and stage controls; PIPE_HAZARD_PERF_CNT_EN adds perf counters
interface pipeline_hazard_ctrl_if;
  logic [4:0]  idRs;
  logic [4:0]  idRt;
  logic        exMemRead;
  logic [4:0]  exRt;
  logic        exBranchTaken;
  logic        memReq;
  logic        memReady;
  logic        pcWrite;
  logic        ifIdWrite;
  logic        ifIdFlush;
  logic        idExWrite;
  logic        idExFlush;
  logic        exMemWrite;
  logic        memWbBubble;
  logic        memError;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stallCycles;
  logic [31:0] flushCount;
`endif

  modport master (
`ifdef PIPE_HAZARD_PERF_CNT_EN
    input  stallCycles, flushCount,
`endif
    output idRs, idRt, exMemRead, exRt, exBranchTaken, memReq, memReady,
    input  pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite,
           memWbBubble, memError
  );

  modport slave (
`ifdef PIPE_HAZARD_PERF_CNT_EN
    output stallCycles, flushCount,
`endif
    input  idRs, idRt, exMemRead, exRt, exBranchTaken, memReq, memReady,
    output pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite,
           memWbBubble, memError
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// rtl/pipeline_hazard_ctrl_load_use_detect.sv - combinational load-use hazard comparator
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       exMemRead,
  input  logic [4:0] exRt,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  output logic       hazard
);

  // r0 is hardwired to zero, so a load targeting it can never create a dependency.
  assign hazard = exMemRead && (exRt != REG_ZERO) && ((exRt == idRs) || (exRt == idRt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush sequencer; PIPE_HAZARD_PERF_CNT_EN adds perf counters
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int WAIT_W  = cnt_width(MEM_TIMEOUT);
  localparam int FLUSH_W = cnt_width(FLUSH_CYCLES);
  localparam logic [WAIT_W-1:0]  TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST  = FLUSH_W'(FLUSH_CYCLES - 1);

  state_t               state, state_nxt;
  logic [WAIT_W-1:0]    wait_cnt, wait_cnt_nxt;
  logic [FLUSH_W-1:0]   flush_cnt, flush_cnt_nxt;

  logic hazard;
  logic mem_stall;
  logic freeze;
  logic lu_stall;
  logic if_flush;
  logic id_flush;
  logic bubble;
  logic err;
  logic branch_evt;

  load_use_detect u_load_use_detect (
    .exMemRead (hz.exMemRead),
    .exRt      (hz.exRt),
    .idRs      (hz.idRs),
    .idRt      (hz.idRt),
    .hazard    (hazard)
  );

  assign mem_stall = hz.memReq & ~hz.memReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    flush_cnt_nxt = flush_cnt;
    freeze        = 1'b0;
    lu_stall      = 1'b0;
    if_flush      = 1'b0;
    id_flush      = 1'b0;
    bubble        = 1'b0;
    err           = 1'b0;
    branch_evt    = 1'b0;
    case (state)
      RUN: begin
        if (mem_stall) begin
          freeze       = 1'b1;
          bubble       = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end else if (hz.exBranchTaken) begin
          branch_evt = 1'b1;
          if_flush   = 1'b1;
          id_flush   = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = FLUSH_W'(1);
          end
        end else if (hazard) begin
          lu_stall = 1'b1;
          id_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (hz.memReady) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == TIMEOUT_VAL) begin
          // Abort: let the pipeline move on but keep the dead load out of writeback.
          err          = 1'b1;
          bubble       = 1'b1;
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else begin
          freeze       = 1'b1;
          bubble       = 1'b1;
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      FLUSH: begin
        if (mem_stall) begin
          freeze        = 1'b1;
          bubble        = 1'b1;
          state_nxt     = MEM_WAIT;
          wait_cnt_nxt  = WAIT_W'(1);
          flush_cnt_nxt = '0;
        end else begin
          if_flush = 1'b1;
          if (flush_cnt == FLUSH_LAST) begin
            state_nxt     = RUN;
            flush_cnt_nxt = '0;
          end else begin
            flush_cnt_nxt = flush_cnt + FLUSH_W'(1);
          end
        end
      end
      default: begin
        state_nxt     = RUN;
        wait_cnt_nxt  = '0;
        flush_cnt_nxt = '0;
      end
    endcase
  end

  assign hz.pcWrite     = ~reset & ~freeze & ~lu_stall;
  assign hz.ifIdWrite   = ~reset & ~freeze & ~lu_stall;
  assign hz.idExWrite   = ~reset & ~freeze;
  assign hz.exMemWrite  = ~reset & ~freeze;
  assign hz.ifIdFlush   = reset | if_flush;
  assign hz.idExFlush   = reset | id_flush;
  assign hz.memWbBubble = reset | bubble;
  assign hz.memError    = ~reset & err;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!hz.pcWrite && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (branch_evt && (flush_count_q != '1))   flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign hz.stallCycles = stall_cycles_q;
  assign hz.flushCount  = flush_count_q;
`else
  logic unused_branch_evt;
  assign unused_branch_evt = branch_evt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES (3),
    .MEM_TIMEOUT  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  // {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memWbBubble, memError}
  localparam logic [7:0] O_RST   = 8'b0010_1010;
  localparam logic [7:0] O_RUN   = 8'b1101_0100;
  localparam logic [7:0] O_LU    = 8'b0001_1100;
  localparam logic [7:0] O_STALL = 8'b0000_0010;
  localparam logic [7:0] O_TMO   = 8'b1101_0111;
  localparam logic [7:0] O_BR    = 8'b1111_1100;
  localparam logic [7:0] O_FL    = 8'b1111_0100;

  function automatic logic [7:0] outs();
    return {hz.pcWrite, hz.ifIdWrite, hz.ifIdFlush, hz.idExWrite,
            hz.idExFlush, hz.exMemWrite, hz.memWbBubble, hz.memError};
  endfunction

  // Apply one cycle of inputs, check outputs mid-cycle, then advance past the edge.
  task automatic step(input string tag, input logic rst, input logic br,
                      input logic mreq, input logic mrdy, input logic emr,
                      input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [7:0] exp);
    logic [7:0] obs;
    reset            = rst;
    hz.exBranchTaken = br;
    hz.memReq        = mreq;
    hz.memReady      = mrdy;
    hz.exMemRead     = emr;
    hz.exRt          = ert;
    hz.idRs          = rs;
    hz.idRt          = rt;
    @(negedge clk);
    obs = outs();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   tag            rst br mreq rdy emr ert    rs     rt
    step("reset_c0",    1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_RST);
    step("reset_c1",    1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_RST);
    step("post_reset",  0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_RUN);

    step("lu_rs",       0, 0, 0, 0, 1, 5'd8,  5'd8,  5'd3,  O_LU);
    step("lu_clear",    0, 0, 0, 0, 0, 5'd8,  5'd8,  5'd3,  O_RUN);
    step("lu_rt",       0, 0, 0, 0, 1, 5'd8,  5'd1,  5'd8,  O_LU);
    step("lu_r0",       0, 0, 0, 0, 1, 5'd0,  5'd0,  5'd0,  O_RUN);
    step("lu_nomatch",  0, 0, 0, 0, 1, 5'd8,  5'd9,  5'd10, O_RUN);

    step("mem_ready0",  0, 0, 1, 1, 0, 5'd0,  5'd0,  5'd0,  O_RUN);

    step("mem_s0",      0, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  O_STALL);
    step("mem_s1",      0, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  O_STALL);
    step("mem_s2",      0, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  O_STALL);
    step("mem_release", 0, 0, 1, 1, 0, 5'd0,  5'd0,  5'd0,  O_RUN);
    step("mem_after",   0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_RUN);

    step("tmo_s0",      0, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  O_STALL);
    step("tmo_s1",      0, 1, 1, 0, 1, 5'd8,  5'd8,  5'd0,  O_STALL);
    step("tmo_s2",      0, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  O_STALL);
    step("tmo_s3",      0, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  O_STALL);
    step("tmo_pulse",   0, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  O_TMO);
    step("tmo_run",     0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_RUN);

    step("br_lu",       0, 1, 0, 0, 1, 5'd8,  5'd8,  5'd0,  O_BR);
    step("br_fl1",      0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_FL);
    step("br_fl2",      0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_FL);
    step("br_done",     0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_RUN);

    step("brmem_stall", 0, 1, 1, 0, 0, 5'd0,  5'd0,  5'd0,  O_STALL);
    step("brmem_rel",   0, 1, 1, 1, 0, 5'd0,  5'd0,  5'd0,  O_RUN);
    step("brmem_br",    0, 1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_BR);
    step("brmem_fl1",   0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_FL);
    step("brmem_fl2",   0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_FL);
    step("brmem_done",  0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_RUN);

    step("flmem_br",    0, 1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_BR);
    step("flmem_stall", 0, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  O_STALL);
    step("flmem_rel",   0, 0, 1, 1, 0, 5'd0,  5'd0,  5'd0,  O_RUN);
    step("flmem_drop",  0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_RUN);

    step("rstw_stall",  0, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  O_STALL);
    step("rstw_s1",     0, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  O_STALL);
    step("rstw_reset",  1, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  O_RST);
    step("rstw_run",    0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_RUN);
    step("rstw_run2",   0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_RUN);

    step("rstf_br",     0, 1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_BR);
    step("rstf_reset",  1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_RST);
    step("rstf_run",    0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_RUN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
